// File: rtl/accel_cmd_sequencer_if.sv
// Host command channel into the accelerator command sequencer.
//   cmd_data  : 32-bit configuration/trigger word from the host
//   cmd_valid : host word valid
//   cmd_ready : sequencer FIFO can accept a word this cycle
// master = host side, slave = sequencer side.
interface accel_cmd_sequencer_if;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;

  modport master (output cmd_data, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_data, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/accel_cmd_sequencer.sv
// Command sequencer in front of the accelerator top. Buffers host words in a
// FIFO, issues them one per cycle onto `instruction`, parks after each trigger
// word until `accel_done`, then re-arms the accelerator with a reset pulse.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   cmd               : host command channel (slave side)
//   instruction       : registered word to the accelerator, 0 when idle
//   accel_rst_ext     : registered reset/re-arm to the accelerator
//   accel_done        : accelerator layer completion
//   busy              : low only while issuing with an empty FIFO
//   layer_done        : one-cycle pulse when a layer ends (done or timeout)
//   layers_completed  : successful layer count, wraps
//   err_bad_opcode    : sticky, a non-zero non-EXTEND word was popped
//   err_timeout       : sticky, watchdog aborted a layer
//   fifo_level        : current FIFO occupancy
module accel_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned REARM_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                          clk,
  input  logic                          rst_n,
  accel_cmd_sequencer_if.slave          cmd,
  output logic [31:0]                   instruction,
  output logic                          accel_rst_ext,
  input  logic                          accel_done,
  output logic                          busy,
  output logic                          layer_done,
  output logic [15:0]                   layers_completed,
  output logic                          err_bad_opcode,
  output logic                          err_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned RCNT_W = $clog2(REARM_CYCLES + 1);
  localparam int unsigned WCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [6:0]        OP_EXTEND  = 7'b0001011;
  localparam logic [4:0]        RD_TRIGGER = 5'b11111;
  localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(FIFO_DEPTH);
  localparam logic [RCNT_W-1:0] RCNT_LOAD  = RCNT_W'(REARM_CYCLES);
  // Watchdog fires at the end of WAIT_DONE cycle number TIMEOUT_CYCLES.
  localparam logic [WCNT_W-1:0] WAIT_LAST  =
    (TIMEOUT_CYCLES != 0) ? WCNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_REARM = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [31:0]        instr_q, instr_d;
  logic               rst_ext_q, rst_ext_d;
  logic               layer_done_q, layer_done_d;
  logic [15:0]        layers_q, layers_d;
  logic               err_bad_q, err_bad_d;
  logic               err_to_q, err_to_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [31:0]        mem_q [FIFO_DEPTH];

  logic        push;
  logic        pop;
  logic [31:0] head;
  logic        head_is_ext;
  logic        head_is_trig;

  assign cmd.cmd_ready = (level_q < LVL_FULL);
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign head          = mem_q[rd_ptr_q];
  assign head_is_ext   = (head[6:0] == OP_EXTEND);
  assign head_is_trig  = head_is_ext && (head[11:7] == RD_TRIGGER);

  // FIFO storage, no reset needed: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd.cmd_data;
    end
  end

  // Sequencer next-state and registered outputs.
  always_comb begin
    state_d      = state_q;
    rcnt_d       = rcnt_q;
    wcnt_d       = wcnt_q;
    instr_d      = '0;
    rst_ext_d    = rst_ext_q;
    layer_done_d = 1'b0;
    layers_d     = layers_q;
    err_bad_d    = err_bad_q;
    err_to_d     = err_to_q;
    pop          = 1'b0;

    case (state_q)
      ST_REARM: begin
        rst_ext_d = 1'b1;
        if (rcnt_q <= RCNT_W'(1)) begin
          state_d   = ST_ISSUE;
          rst_ext_d = 1'b0;
        end else begin
          rcnt_d = rcnt_q - RCNT_W'(1);
        end
      end

      ST_ISSUE: begin
        rst_ext_d = 1'b0;
        if (level_q != '0) begin
          pop = 1'b1;
          if (head_is_ext) begin
            instr_d = head;
            if (head_is_trig) begin
              state_d = ST_WAIT;
              wcnt_d  = '0;
            end
          end else if (head != '0) begin
            err_bad_d = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        // Saturate so a disabled watchdog never wraps back into the mask cycle.
        if (wcnt_q != '1) begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
        // wcnt_q == 0 is the first WAIT cycle: a stale done is masked there.
        if ((wcnt_q != '0) && accel_done) begin
          state_d      = ST_REARM;
          rcnt_d       = RCNT_LOAD;
          rst_ext_d    = 1'b1;
          layer_done_d = 1'b1;
          layers_d     = layers_q + 16'd1;
        end else if ((TIMEOUT_CYCLES != 0) && (wcnt_q == WAIT_LAST)) begin
          state_d      = ST_REARM;
          rcnt_d       = RCNT_LOAD;
          rst_ext_d    = 1'b1;
          layer_done_d = 1'b1;
          err_to_d     = 1'b1;
        end
      end

      default: begin
        state_d   = ST_REARM;
        rcnt_d    = RCNT_LOAD;
        rst_ext_d = 1'b1;
      end
    endcase

    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    busy_d   = !((state_d == ST_ISSUE) && (level_d == '0));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_REARM;
      rcnt_q       <= RCNT_LOAD;
      wcnt_q       <= '0;
      instr_q      <= '0;
      rst_ext_q    <= 1'b1;
      layer_done_q <= 1'b0;
      layers_q     <= '0;
      err_bad_q    <= 1'b0;
      err_to_q     <= 1'b0;
      busy_q       <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      wcnt_q       <= wcnt_d;
      instr_q      <= instr_d;
      rst_ext_q    <= rst_ext_d;
      layer_done_q <= layer_done_d;
      layers_q     <= layers_d;
      err_bad_q    <= err_bad_d;
      err_to_q     <= err_to_d;
      busy_q       <= busy_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
    end
  end

  assign instruction      = instr_q;
  assign accel_rst_ext    = rst_ext_q;
  assign busy             = busy_q;
  assign layer_done       = layer_done_q;
  assign layers_completed = layers_q;
  assign err_bad_opcode   = err_bad_q;
  assign err_timeout      = err_to_q;
  assign fifo_level       = level_q;

endmodule

// File: doc/accel_cmd_sequencer.md
Name: accel_cmd_sequencer

Overview:
- Sits directly upstream of the accelerator top and owns its `instruction` and `rst_ext` inputs.
- Buffers 32-bit configuration/trigger words pushed by the host, issues them one per cycle, and parks after each trigger word until the accelerator raises `accel_done`.
- Then re-arms the accelerator with a reset pulse and continues with the next layer's words.
- Provides layer-completion pulses, a completed-layer count, and error flags (bad opcode, timeout).

Parameters:
- FIFO_DEPTH, 16, command FIFO entries; power of two, ≥2.
- REARM_CYCLES, 2, cycles `accel_rst_ext` is held high after each layer and after reset; ≥1.
- TIMEOUT_CYCLES, 1048576, maximum WAIT_DONE cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_data  in  32  host command word.
- cmd_valid  in  1  host word valid.
- cmd_ready  out  1  FIFO can accept; equals (level < FIFO_DEPTH), registered-state only.
- instruction  out  32  registered word to accelerator; 0 when not issuing.
- accel_rst_ext  out  1  registered reset/re-arm to accelerator.
- accel_done  in  1  accelerator completion.
- busy  out  1  high in any state except ISSUE-with-empty-FIFO.
- layer_done  out  1  one-cycle pulse on done or timeout exit from WAIT_DONE.
- layers_completed  out  16  count of successful layers; wraps 0xFFFF→0.
- err_bad_opcode  out  1  sticky.
- err_timeout  out  1  sticky.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, instruction=0, accel_rst_ext=1, layer_done=0, layers_completed=0, both errors=0, state=REARM with the rearm counter loaded to REARM_CYCLES.
- Push: on any cycle with cmd_valid & cmd_ready. Writes at FIFO_DEPTH are blocked by cmd_ready=0.
  - Push and pop in the same cycle are legal; the level is unchanged.
- Opcode: cmd_data[6:0]. EXTEND = 7'b0001011. Trigger = EXTEND with rd field [11:7] = 5'b11111.
- States:
  - REARM: accel_rst_ext=1, instruction=0. Decrement the counter each cycle; at 1, go to ISSUE next edge (accel_rst_ext=0 from then on). No pops.
  - ISSUE: if the FIFO is non-empty, pop one word per cycle and register it onto instruction at the next edge.
    - Word 0x00000000 is popped silently; instruction=0.
    - Non-zero, non-EXTEND opcode: popped, instruction=0, err_bad_opcode set.
    - EXTEND non-trigger: driven on instruction for exactly one cycle; stay in ISSUE.
    - Trigger: driven for one cycle; go to WAIT_DONE; watchdog counter cleared.
    - If the FIFO is empty, instruction=0.
  - WAIT_DONE: instruction=0, no pops.
    - accel_done is ignored in the first WAIT_DONE cycle (mask against a stale done).
    - From the 2nd cycle, accel_done=1 causes layer_done pulse, layers_completed+1, and REARM.
    - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES without done: err_timeout set, layer_done pulse, count NOT incremented, go to REARM.
    - If done and timeout occur on the same cycle, done wins.
- Latency: word pushed at edge t into an empty FIFO in ISSUE appears on instruction after edge t+1, i.e. it is valid during cycle t+1→t+2. Back-to-back words issue on consecutive cycles.
- Trigger-to-next-word gap: at least 1 mask cycle + done wait + REARM_CYCLES + 1.
- Pushes continue to be accepted in every state, including REARM and WAIT_DONE.
- The error flags are cleared only by rst_n.
- rst_n asserted mid-layer: everything returns to reset values immediately, asynchronously. accel_rst_ext goes 1 at once, and buffered words are lost.

Test Plan:
- Reset then idle: rst_n low 3 cycles then high → accel_rst_ext=1 for exactly 2 cycles after release, then 0; instruction=0; busy=0; fifo_level=0.
- Config burst: push 0x0000400B (rd=0, imm dim=4), 0x0000308B (rd=1, depth 3), 0x00000F8B (trigger) on consecutive cycles → same words on instruction on 3 consecutive cycles starting 2 cycles after the first push; then instruction=0 and busy=1.
- Done handshake: after trigger, hold accel_done=1 immediately → ignored in the mask cycle, accepted the next cycle. layer_done pulses once, layers_completed=1, accel_rst_ext high for 2 cycles; a pre-queued 0x0000400B issues on the first cycle after rearm.
- Backpressure: TB holds accel_done=0, pushes 17 words after a trigger (DEPTH=16) → cmd_ready=0 at level 16, the 17th is held; on done the FIFO drains one word per cycle and cmd_ready returns 1 after the first pop.
- Bad opcode: push 0x00000013 then 0x0000400B → err_bad_opcode=1; instruction stays 0 for the first, 0x0000400B issues one cycle later.
- Timeout and reset: TIMEOUT_CYCLES=8, trigger with no done → err_timeout=1 on the 8th WAIT_DONE cycle, layer_done pulse, layers_completed unchanged, REARM. Then rst_n pulse mid-REARM → all outputs return to reset values asynchronously and both errors clear.
